// File: rtl/tff_bank_counter_if.sv
// Control/data bundle for tff_bank_counter: mode select and operands in,
// register state, complement and terminal-count pulse out.
interface tff_bank_counter_if #(
    parameter int WIDTH = 4
);
    logic             en;
    logic [1:0]       mode;
    logic [WIDTH-1:0] d;
    logic [WIDTH-1:0] t;
    logic             up;
    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] qb;
    logic             tc;

    modport master (output en, mode, d, t, up, input  q, qb, tc);
    modport slave  (input  en, mode, d, t, up, output q, qb, tc);
endinterface

// File: rtl/tff_bank_counter.sv
// WIDTH-bit register bank: hold, saturating parallel load, per-bit T-toggle,
// or modulo-(MAX_COUNT+1) up/down count with a registered terminal-count pulse.
module tff_bank_counter #(
    parameter int               WIDTH     = 4,
    parameter logic [WIDTH-1:0] MAX_COUNT = '1,
    parameter logic [WIDTH-1:0] RST_VAL   = '0
) (
    input  logic              clk,
    input  logic              rst,
    tff_bank_counter_if.slave bus
);
    typedef enum logic [1:0] {
        M_HOLD   = 2'b00,
        M_LOAD   = 2'b01,
        M_TOGGLE = 2'b10,
        M_COUNT  = 2'b11
    } mode_e;

    logic [WIDTH-1:0] q_r;
    logic             tc_r;
    logic [WIDTH-1:0] q_nxt;
    logic             tc_nxt;
    mode_e            mode;

    assign mode = mode_e'(bus.mode);

    always_comb begin
        q_nxt  = q_r;
        tc_nxt = 1'b0;
        if (bus.en) begin
            case (mode)
                M_HOLD:   q_nxt = q_r;
                M_LOAD:   q_nxt = (bus.d > MAX_COUNT) ? MAX_COUNT : bus.d;
                // Toggle is deliberately not range-limited; COUNT recovers.
                M_TOGGLE: q_nxt = q_r ^ bus.t;
                M_COUNT: begin
                    if (bus.up) begin
                        if (q_r >= MAX_COUNT) begin
                            q_nxt  = '0;
                            tc_nxt = 1'b1;
                        end else begin
                            q_nxt = q_r + WIDTH'(1);
                        end
                    end else begin
                        if (q_r == '0) begin
                            q_nxt  = MAX_COUNT;
                            tc_nxt = 1'b1;
                        end else if (q_r > MAX_COUNT) begin
                            q_nxt = MAX_COUNT;
                        end else begin
                            q_nxt = q_r - WIDTH'(1);
                        end
                    end
                end
                default:  q_nxt = q_r;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q_r  <= RST_VAL;
            tc_r <= 1'b0;
        end else begin
            q_r  <= q_nxt;
            tc_r <= tc_nxt;
        end
    end

    assign bus.q  = q_r;
    assign bus.qb = ~q_r;
    assign bus.tc = tc_r;
endmodule

// File: tb/tb_tff_bank_counter.sv
// Bench for tff_bank_counter: vector table, async-reset sequences, random
// stimulus against a modular-arithmetic reference model, and a 1-bit instance.
module tb_tff_bank_counter;
    localparam int MAXC = 9;
    localparam int RSTV = 3;

    typedef struct {
        logic       en;
        logic [1:0] mode;
        logic [3:0] d;
        logic [3:0] t;
        logic       up;
        logic [3:0] eq;
        logic       etc;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   ncmp = 0;
    int   nfail = 0;
    int   mq;
    int   mtc;
    vec_t tbl[$];

    always #5 clk = ~clk;

    tff_bank_counter_if #(.WIDTH(4)) b0 ();
    tff_bank_counter_if #(.WIDTH(1)) b1 ();

    tff_bank_counter #(.WIDTH(4), .MAX_COUNT(4'd9), .RST_VAL(4'd3)) dut0 (
        .clk(clk), .rst(rst), .bus(b0.slave));
    tff_bank_counter #(.WIDTH(1), .MAX_COUNT(1'b1), .RST_VAL(1'b0)) dut1 (
        .clk(clk), .rst(rst), .bus(b1.slave));

    function automatic vec_t mk(logic en, logic [1:0] mode, logic [3:0] d, logic [3:0] t,
                                logic up, logic [3:0] eq, logic etc);
        vec_t v;
        v.en = en; v.mode = mode; v.d = d; v.t = t; v.up = up; v.eq = eq; v.etc = etc;
        return v;
    endfunction

    task automatic chk(string nm, logic [3:0] eq, logic etc);
        logic [3:0] eqb;
        eqb = ~eq;
        ncmp++;
        if (b0.q !== eq || b0.qb !== eqb || b0.tc !== etc) begin
            nfail++;
            $display("FAIL %s: got q=%0d qb=%b tc=%b, want q=%0d qb=%b tc=%b",
                     nm, b0.q, b0.qb, b0.tc, eq, eqb, etc);
        end
    endtask

    task automatic chk1(string nm, logic eq, logic etc);
        ncmp++;
        if (b1.q !== eq || b1.qb !== ~eq || b1.tc !== etc) begin
            nfail++;
            $display("FAIL %s: got q=%b qb=%b tc=%b, want q=%b qb=%b tc=%b",
                     nm, b1.q, b1.qb, b1.tc, eq, ~eq, etc);
        end
    endtask

    // Reference: counting viewed as arithmetic modulo MAXC+1.
    task automatic model(logic en, logic [1:0] mode, logic [3:0] d, logic [3:0] t, logic up);
        mtc = 0;
        if (en) begin
            case (mode)
                2'd1: mq = (int'(d) > MAXC) ? MAXC : int'(d);
                2'd2: mq = (mq ^ int'(t)) & 15;
                2'd3: begin
                    if (up) begin
                        if (mq > MAXC) begin mq = 0; mtc = 1; end
                        else begin mq = (mq + 1) % (MAXC + 1); mtc = (mq == 0); end
                    end else begin
                        if (mq > MAXC) mq = MAXC;
                        else begin mtc = (mq == 0); mq = (mq + MAXC) % (MAXC + 1); end
                    end
                end
                default: ;
            endcase
        end
    endtask

    task automatic step(logic en, logic [1:0] mode, logic [3:0] d, logic [3:0] t, logic up);
        b0.en = en; b0.mode = mode; b0.d = d; b0.t = t; b0.up = up;
        @(posedge clk);
        model(en, mode, d, t, up);
        #1;
    endtask

    initial begin
        b0.en = 0; b0.mode = 0; b0.d = 0; b0.t = 0; b0.up = 0;
        b1.en = 0; b1.mode = 0; b1.d = 0; b1.t = 0; b1.up = 0;

        // toggle
        tbl.push_back(mk(1, 2'd1, 4'd0, 4'd0, 0, 4'd0, 0));
        tbl.push_back(mk(1, 2'd2, 4'd0, 4'b0101, 0, 4'b0101, 0));
        tbl.push_back(mk(1, 2'd2, 4'd0, 4'b0101, 0, 4'b0000, 0));
        tbl.push_back(mk(1, 2'd2, 4'd0, 4'b0000, 0, 4'b0000, 0));
        tbl.push_back(mk(0, 2'd2, 4'd0, 4'b1111, 0, 4'b0000, 0));
        // decade up-count
        for (int i = 1; i <= 12; i++)
            tbl.push_back(mk(1, 2'd3, 4'd0, 4'd0, 1, 4'(i % 10), (i == 10)));
        // saturating load, down-count with wrap
        tbl.push_back(mk(1, 2'd1, 4'd14, 4'd0, 0, 4'd9, 0));
        for (int i = 1; i <= 10; i++)
            tbl.push_back(mk(1, 2'd3, 4'd0, 4'd0, 0, (i == 10) ? 4'd9 : 4'(9 - i), (i == 10)));
        // out-of-range recovery
        tbl.push_back(mk(1, 2'd1, 4'd0, 4'd0, 0, 4'd0, 0));
        tbl.push_back(mk(1, 2'd2, 4'd0, 4'b1111, 0, 4'd15, 0));
        tbl.push_back(mk(1, 2'd3, 4'd0, 4'd0, 0, 4'd9, 0));
        tbl.push_back(mk(1, 2'd0, 4'd3, 4'd5, 1, 4'd9, 0));

        repeat (2) @(posedge clk);
        #1;
        chk("rst_init", 4'd3, 0);
        chk1("rst_init_w1", 1'b0, 0);
        rst = 0;
        mq = RSTV; mtc = 0;
        step(1, 2'd1, 4'd5, 4'd0, 0);
        chk("load5", 4'd5, 0);

        // async assert between edges
        #3; rst = 1; #1;
        chk("rst_async", 4'd3, 0);
        repeat (2) begin
            @(posedge clk); #1;
            chk("rst_hold", 4'd3, 0);
        end
        rst = 0;
        mq = RSTV; mtc = 0;

        foreach (tbl[i]) begin
            step(tbl[i].en, tbl[i].mode, tbl[i].d, tbl[i].t, tbl[i].up);
            chk($sformatf("tbl[%0d]", i), tbl[i].eq, tbl[i].etc);
        end

        // reset mid-count aborts the pending wrap pulse
        step(1, 2'd1, 4'd9, 4'd0, 0);
        chk("load9", 4'd9, 0);
        b0.mode = 2'd3; b0.up = 1;
        #2; rst = 1; #1;
        chk("rst_midcount", 4'd3, 0);
        @(posedge clk); #1;
        chk("rst_no_tc", 4'd3, 0);
        #2; rst = 0;
        mq = RSTV; mtc = 0;
        step(1, 2'd3, 4'd0, 4'd0, 1);
        chk("resume", 4'd4, 0);

        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(0, 9) != 0), 2'($urandom_range(0, 3)),
                 4'($urandom), 4'($urandom), 1'($urandom));
            chk($sformatf("rand[%0d]", i), 4'(mq), 1'(mtc));
        end

        // 1-bit instance
        b0.en = 0;
        b1.en = 1; b1.mode = 2'd3; b1.up = 1; b1.t = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            chk1($sformatf("w1_count[%0d]", i), (i % 2 == 0), (i % 2 == 1));
        end
        b1.mode = 2'd2; b1.t = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            chk1($sformatf("w1_toggle[%0d]", i), (i % 2 == 0), 1'b0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end
endmodule

// File: doc/tff_bank_counter.md
Name: tff_bank_counter

Overview:
- Parametrised successor to the single-bit toggle flip-flop.
- A WIDTH-bit register bank that runs in one of four modes, selected each cycle:
  - hold,
  - parallel D-load,
  - per-bit T-toggle,
  - modulo up/down count with a terminal-count pulse.
- qb is the complement output.
- Serves as the general-purpose toggle/counter register for later counter and divider exercises.

Parameters:
- WIDTH, 4, register width in bits (1..32).
- MAX_COUNT, 2**WIDTH-1, counting modulus minus one; legal range 1..2**WIDTH-1.
- RST_VAL, 0, value loaded into q on reset; must be <= MAX_COUNT.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- en  input  1  clock enable; 0 forces hold.
- mode  input  2  00 HOLD, 01 LOAD, 10 TOGGLE, 11 COUNT.
- d  input  WIDTH  parallel load data (LOAD mode).
- t  input  WIDTH  per-bit toggle mask (TOGGLE mode).
- up  input  1  count direction in COUNT mode: 1 up, 0 down.
- q  output  WIDTH  register state.
- qb  output  WIDTH  always ~q (combinational from q).
- tc  output  1  registered terminal-count pulse.

Behaviour:
- Reset:
  - rst high: q = RST_VAL, qb = ~RST_VAL, tc = 0 immediately, independent of clk.
  - Reset held across edges: outputs stay at reset values.
  - Deassertion: the first rising edge after rst falls applies normal operation.
  - Reset mid-count aborts any pending tc.
- All state updates occur on the rising clk edge. Latency is 1 cycle from inputs sampled at an edge to q/tc.
- en = 0: q holds, tc = 0 (regardless of mode).
- HOLD (00): q holds, tc = 0.
- LOAD (01):
  - q <= d if d <= MAX_COUNT, else q <= MAX_COUNT (saturating load).
  - tc = 0.
- TOGGLE (10):
  - q <= q ^ t, bitwise; each bit behaves as an independent T flip-flop.
  - The result is not range-limited (may exceed MAX_COUNT). tc = 0.
- COUNT (11), up = 1:
  - q < MAX_COUNT: q <= q+1, tc <= 0.
  - q >= MAX_COUNT: q <= 0, tc <= 1 (wrap).
- COUNT (11), up = 0:
  - q == 0: q <= MAX_COUNT, tc <= 1 (wrap).
  - q > MAX_COUNT (reachable only via TOGGLE): q <= MAX_COUNT, tc <= 0.
  - Otherwise: q <= q-1, tc <= 0.
- tc timing:
  - High for exactly one cycle, coincident with the wrapped q value.
  - Back-to-back wraps (e.g. MAX_COUNT = 1, continuous count) keep tc high on each wrapping edge.
- Arithmetic is unsigned, WIDTH bits; no carries beyond WIDTH.
- Mode or direction changes take effect on the next edge; no internal state beyond q and tc.
- qb never lags q (no clocked qb); no X on any output after reset.

Test Plan:
1. Reset: WIDTH=4, RST_VAL=3.
   - Assert rst between clock edges -> q = 3, qb = 4'b1100, tc = 0 immediately.
   - Hold rst 2 cycles -> values unchanged.
2. Toggle: reset to 0, mode = 10.
   - t = 4'b0101 for 2 edges -> q = 0101, then 0000.
   - t = 0 -> q holds.
   - en = 0 with t = 1111 -> no change.
3. Decade up-count: MAX_COUNT = 9, mode = 11, up = 1, from 0 for 12 edges.
   - q = 1..9, 0, 1, 2.
   - tc = 1 only on the edge producing q = 0.
4. Down-count and saturating load: MAX_COUNT = 9.
   - LOAD d = 14 -> q = 9.
   - Count down 10 edges -> 8..0, then 9 with tc = 1 on the 9.
   - TOGGLE t = 1111 from 0 -> q = 15; then COUNT down -> q = 9, tc = 0.
5. Simultaneous/async events:
   - rst asserted mid-count with q = 9, up = 1 -> q = RST_VAL immediately; no tc pulse follows.
   - Release rst -> counting resumes from RST_VAL on the next edge.
6. Edge parameters:
   - WIDTH = 1, MAX_COUNT = 1, COUNT up -> q alternates 1,0,... with tc = 1 on every 0; TOGGLE t = 1 gives the same q sequence with tc = 0.
